fifo_frame_builder: RTL and testbench

Downstream read-side stage for the serial-capture FIFO in Parallel_Serial_top. It drains 36-bit capture words through the FIFO read port (fifo_rd_en/fifo_empty/fifo_q) and wraps them into framed packets for the readout link. Each frame is a header word, up to FRAME_WORDS payload words, and a trailer carrying the payload count and a checksum. Output is a 36-bit valid/ready stream feeding the readout/transmit logic.

---
 rtl/fifo_frame_pkg.sv | 15 +
 rtl/frame_skid_buf.sv | 57 +++++
 rtl/fifo_frame_builder.sv | 135 +++++++++++++
 tb/tb_fifo_frame_builder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the capture-FIFO frame builder.
package fifo_frame_pkg;
  localparam int WORD_W = 36;
  localparam int CNT_W  = 16;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam logic [3:0] TRL_TAG = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_TRL
  } state_t;
endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus one holding slot.
// The writer must reserve room using the occupancy output; in_valid is never refused.
module frame_skid_buf
  import fifo_frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);
  logic [WORD_W-1:0] out_data_reg, out_data_next, hold_data_reg, hold_data_next;
  logic              out_valid_reg, out_valid_next, hold_valid_reg, hold_valid_next;

  always_comb begin
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;
    hold_data_next  = hold_data_reg;
    hold_valid_next = hold_valid_reg;
    if (!out_valid_reg || out_ready) begin
      // Output slot frees up: the older held word goes first to keep order.
      if (hold_valid_reg) begin
        out_data_next   = hold_data_reg;
        out_valid_next  = 1'b1;
        hold_data_next  = in_data;
        hold_valid_next = in_valid;
      end else begin
        out_data_next  = in_data;
        out_valid_next = in_valid;
      end
    end else if (in_valid) begin
      hold_data_next  = in_data;
      hold_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      hold_data_reg  <= '0;
      hold_valid_reg <= 1'b0;
    end else begin
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      hold_data_reg  <= hold_data_next;
      hold_valid_reg <= hold_valid_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign occupancy = {1'b0, out_valid_reg} + {1'b0, hold_valid_reg};
endmodule

// File: rtl/fifo_frame_builder.sv
// Drains a non-FWFT capture FIFO and wraps its words into header/payload/trailer
// frames on a 36-bit valid/ready stream.
module fifo_frame_builder
  import fifo_frame_pkg::*;
#(
  parameter int          FRAME_WORDS = 10,
  parameter int          TIMEOUT     = 64,
  parameter logic [15:0] HDR_MAGIC   = 16'h5A5A
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_q,
  output logic              fifo_rd_en,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy,
  output logic              timeout_flag
);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] req_cnt_reg, req_cnt_next, rcv_cnt_reg, rcv_cnt_next;
  logic [CNT_W-1:0] csum_reg, csum_next, idle_cnt_reg, idle_cnt_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic             inflight_reg, timeout_flag_reg, timeout_flag_next;

  logic [WORD_W-1:0] buf_data;
  logic              buf_valid, buf_ready;
  logic [1:0]        buf_occ;
  logic [2:0]        pending;
  logic              has_room;

  // The FIFO word arrives one cycle after the strobe, so inflight_reg is its valid.
  frame_skid_buf u_skid (
    .clk       (clk_in),
    .rst       (rst),
    .in_data   (fifo_q),
    .in_valid  (inflight_reg),
    .out_data  (buf_data),
    .out_valid (buf_valid),
    .out_ready (buf_ready),
    .occupancy (buf_occ)
  );

  assign buf_ready = dout_ready && (state_reg == ST_PAYLOAD);
  // A read may issue if buffered plus in-flight words, minus the one leaving now, is at most 1.
  assign pending  = {1'b0, buf_occ} + {2'b00, inflight_reg};
  assign has_room = pending <= ({2'b00, buf_valid & buf_ready} + 3'd1);

  always_comb begin
    state_next        = state_reg;
    req_cnt_next      = req_cnt_reg;
    rcv_cnt_next      = rcv_cnt_reg;
    csum_next         = csum_reg;
    idle_cnt_next     = idle_cnt_reg;
    frame_cnt_next    = frame_cnt_reg;
    timeout_flag_next = 1'b0;
    fifo_rd_en        = 1'b0;
    dout              = '0;
    dout_valid        = 1'b0;
    if (inflight_reg) begin
      rcv_cnt_next = rcv_cnt_reg + CNT_W'(1);
      csum_next    = csum_reg ^ fifo_q[CNT_W-1:0];
    end
    case (state_reg)
      ST_IDLE: if (enable && !fifo_empty) state_next = ST_HDR;
      ST_HDR: begin
        dout          = {HDR_TAG, HDR_MAGIC, frame_cnt_reg};
        dout_valid    = 1'b1;
        idle_cnt_next = '0;
        if (dout_ready) state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        dout       = buf_data;
        dout_valid = buf_valid;
        fifo_rd_en = !fifo_empty && (req_cnt_reg < FRAME_LAST) && has_room;
        if (fifo_rd_en) req_cnt_next = req_cnt_reg + CNT_W'(1);
        if (rcv_cnt_reg == FRAME_LAST && buf_occ == 2'd0 && !inflight_reg)
          state_next = ST_TRL;
        else if (inflight_reg || fifo_rd_en)
          idle_cnt_next = '0;
        else if (idle_cnt_reg != IDLE_LIMIT)
          idle_cnt_next = idle_cnt_reg + CNT_W'(1);
        else if (buf_occ == 2'd0) begin
          // Expired: close only once stalled payload words have drained.
          timeout_flag_next = 1'b1;
          state_next        = ST_TRL;
        end
      end
      ST_TRL: begin
        dout       = {TRL_TAG, rcv_cnt_reg, csum_reg};
        dout_valid = 1'b1;
        if (dout_ready) begin
          frame_cnt_next = frame_cnt_reg + CNT_W'(1);
          req_cnt_next   = '0;
          rcv_cnt_next   = '0;
          csum_next      = '0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      req_cnt_reg      <= '0;
      rcv_cnt_reg      <= '0;
      csum_reg         <= '0;
      idle_cnt_reg     <= '0;
      frame_cnt_reg    <= '0;
      inflight_reg     <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      req_cnt_reg      <= req_cnt_next;
      rcv_cnt_reg      <= rcv_cnt_next;
      csum_reg         <= csum_next;
      idle_cnt_reg     <= idle_cnt_next;
      frame_cnt_reg    <= frame_cnt_next;
      inflight_reg     <= fifo_rd_en;
      timeout_flag_reg <= timeout_flag_next;
    end
  end

  assign frame_cnt    = frame_cnt_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign timeout_flag = timeout_flag_reg;
endmodule

// File: tb/tb_fifo_frame_builder.sv
// Self-checking bench for fifo_frame_builder: FIFO model, output scoreboard,
// table of frame scenarios plus reset, enable-drop and counter-wrap sequences.
module tb_fifo_frame_builder;
  import fifo_frame_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk_in = 1'b0;
  logic        rst, enable, fifo_empty, fifo_rd_en, dout_valid, dout_ready, busy, timeout_flag;
  logic [35:0] fifo_q, dout;
  logic [15:0] frame_cnt;

  always #5 clk_in = ~clk_in;

  fifo_frame_builder #(.FRAME_WORDS(10), .TIMEOUT(TIMEOUT), .HDR_MAGIC(16'h5A5A)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_q       (fifo_q),
    .fifo_rd_en   (fifo_rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .frame_cnt    (frame_cnt),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  typedef struct {
    int          n;
    int          pat;
    int          gap;
    bit          rnd;
    bit          exp_to;
    logic [35:0] exp_trl;
  } vec_t;

  // Standard-read FIFO model: data appears the cycle after the strobe.
  logic [35:0] fifo_mem [256];
  int          wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  logic [35:0] exp_q [$];
  int          vec_cnt = 0, err_cnt = 0;
  int          cyc = 0, hs_cnt = 0, rd_pulses = 0, to_pulses = 0, last_hs_cyc = 0, to_gap = -1;
  bit          rand_ready = 1'b0, stall_prev = 1'b0;
  logic [35:0] prev_dout = '0;
  logic [15:0] exp_frame = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push_fifo(input logic [35:0] w);
    fifo_mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  // One clock: sample/score at negedge, then update FIFO and drive inputs after posedge.
  task automatic tick();
    logic        rd_now;
    logic [35:0] exp_w;
    @(negedge clk_in);
    rd_now = fifo_rd_en && !rst;
    if (!rst) begin
      if (stall_prev) check("stall_hold", {dout_valid, dout}, {1'b1, prev_dout});
      if (timeout_flag) begin
        to_pulses++;
        to_gap = cyc - last_hs_cyc;
      end
      if (dout_valid && dout_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL extra_word: got %h, want no word", dout);
        end else begin
          exp_w = exp_q.pop_front();
          if (dout !== exp_w) begin
            err_cnt++;
            $display("FAIL txn %0d: got %h, want %h", hs_cnt, dout, exp_w);
          end else
            $display("txn %0d: dout=%h", hs_cnt, dout);
        end
      end
      if (rd_now) begin
        rd_pulses++;
        if (fifo_empty) check("read_when_empty", 1, 0);
      end
      stall_prev = dout_valid && !dout_ready;
      prev_dout  = dout;
    end else
      stall_prev = 1'b0;
    cyc++;
    @(posedge clk_in);
    #1;
    if (rd_now && rd_ptr != wr_ptr) begin
      fifo_q = fifo_mem[rd_ptr % 256];
      rd_ptr++;
    end
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      tick();
      c++;
    end
    check("drain_in_budget", 64'(c < budget), 1);
    if (c >= budget) exp_q.delete();
  endtask

  task automatic run_vec(input vec_t vc);
    logic [35:0] words [$];
    int          base_rd, base_to;
    base_rd    = rd_pulses;
    base_to    = to_pulses;
    to_gap     = -1;
    rand_ready = vc.rnd;
    dout_ready = 1'b1;
    for (int i = 0; i < vc.n; i++) begin
      case (vc.pat)
        0:       words.push_back(36'(i + 1));
        1:       words.push_back(36'(1) << i);
        default: words.push_back({4'h9, 16'hABCD, 16'(i * 5)});
      endcase
    end
    exp_q.push_back({HDR_TAG, 16'h5A5A, exp_frame});
    foreach (words[i]) exp_q.push_back(words[i]);
    exp_q.push_back(vc.exp_trl);
    foreach (words[i]) begin
      push_fifo(words[i]);
      for (int g = 0; g < vc.gap; g++) tick();
    end
    wait_done(2000);
    exp_frame++;
    rand_ready = 1'b0;
    dout_ready = 1'b1;
    check("frame_cnt", frame_cnt, exp_frame);
    check("rd_pulses", rd_pulses - base_rd, vc.n);
    check("timeout_pulses", to_pulses - base_to, vc.exp_to);
    if (vc.exp_to) check("timeout_gap", to_gap, TIMEOUT);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int   hs_base, base_rd, c;
    vecs[0] = '{n:10, pat:0, gap:0, rnd:1'b0, exp_to:1'b0, exp_trl:36'hE_000A_000B};
    vecs[1] = '{n:3,  pat:1, gap:0, rnd:1'b0, exp_to:1'b1, exp_trl:36'hE_0003_0007};
    vecs[2] = '{n:10, pat:0, gap:0, rnd:1'b1, exp_to:1'b0, exp_trl:36'hE_000A_000B};
    vecs[3] = '{n:10, pat:2, gap:0, rnd:1'b1, exp_to:1'b0, exp_trl:36'hE_000A_0035};
    vecs[4] = '{n:10, pat:0, gap:5, rnd:1'b0, exp_to:1'b0, exp_trl:36'hE_000A_000B};
    vecs[5] = '{n:1,  pat:0, gap:0, rnd:1'b0, exp_to:1'b1, exp_trl:36'hE_0001_0001};

    rst        = 1'b1;
    enable     = 1'b0;
    dout_ready = 1'b1;
    fifo_q     = '0;
    repeat (3) tick();
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_flag, 0);
    rst    = 1'b0;
    enable = 1'b1;
    tick();

    foreach (vecs[v]) run_vec(vecs[v]);

    // Reset after the fourth payload word: everything clears at once.
    hs_base = hs_cnt;
    c       = 0;
    exp_q.push_back({HDR_TAG, 16'h5A5A, exp_frame});
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(36'(i));
      push_fifo(36'(i));
    end
    while (hs_cnt - hs_base < 5 && c < 500) begin
      tick();
      c++;
    end
    check("reached_payload", 64'(c < 500), 1);
    rst = 1'b1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_dout_valid", dout_valid, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    wr_ptr     = rd_ptr;
    stall_prev = 1'b0;
    repeat (2) tick();
    rst       = 1'b0;
    exp_frame = '0;
    run_vec(vecs[0]);

    // Enable dropped mid-frame: one frame finishes, 15 words stay queued.
    hs_base = hs_cnt;
    base_rd = rd_pulses;
    c       = 0;
    exp_q.push_back({HDR_TAG, 16'h5A5A, exp_frame});
    for (int i = 1; i <= 10; i++) exp_q.push_back(36'h100 + 36'(i));
    exp_q.push_back(36'hE_000A_000B);
    for (int i = 1; i <= 25; i++) push_fifo(36'h100 + 36'(i));
    while (hs_cnt - hs_base < 2 && c < 500) begin
      tick();
      c++;
    end
    check("en_reached_payload", 64'(c < 500), 1);
    enable = 1'b0;
    wait_done(2000);
    repeat (40) tick();
    exp_frame++;
    check("en_rd_pulses", rd_pulses - base_rd, 10);
    check("en_fifo_left", wr_ptr - rd_ptr, 15);
    check("en_busy", busy, 0);
    check("en_frame_cnt", frame_cnt, exp_frame);
    wr_ptr = rd_ptr;
    enable = 1'b1;
    tick();

    // Frame counter wrap from 16'hFFFF.
    force dut.frame_cnt_reg = 16'hFFFF;
    repeat (2) tick();
    release dut.frame_cnt_reg;
    tick();
    exp_frame = 16'hFFFF;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
